// File: rtl/axilite_master_engine.sv
// axilite_master_engine
//   Single-outstanding AXI4-Lite master. A fabric-side sequencer hands it one
//   command at a time (write or read). The engine runs the matching AXI4-Lite
//   transaction and returns a single response.
//   Optional macro AXIM_TIMEOUT_EN adds a per-phase watchdog that aborts a
//   stalled transaction after TIMEOUT_CYCLES cycles. When it aborts, the
//   response carries RSP_TIMEOUT=1 and RSP_RESP=2'b11.
module axilite_master_engine #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 10
`ifdef AXIM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES   = 1024
`endif
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,
  // command side
  input  logic                              CMD_VALID,
  output logic                              CMD_READY,
  input  logic                              CMD_WRITE,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     CMD_ADDR,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     CMD_WDATA,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   CMD_WSTRB,
  // response side
  output logic                              RSP_VALID,
  input  logic                              RSP_READY,
  output logic                              RSP_WRITE,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     RSP_RDATA,
  output logic [1:0]                        RSP_RESP,
  output logic                              RSP_TIMEOUT,
  output logic                              BUSY,
  // AXI4-Lite write address
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  // AXI4-Lite write data
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  // AXI4-Lite write response
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  // AXI4-Lite read address
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  // AXI4-Lite read data
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic cmd_ready_d;
  logic awvalid_d, wvalid_d, arvalid_d;
  logic bready_d, rready_d;
  logic rsp_valid_d;
  logic latch_cmd, latch_b, latch_r;

`ifdef AXIM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] phase_cnt_q;
  logic             to_fire;
  logic             rsp_timeout_q;
`endif

  // Unprivileged, secure, data accesses only.
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  assign BUSY = (state_q != IDLE);

  // State register.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) state_q <= IDLE;
    else                state_q <= state_d;
  end

  // Next-state logic and next values of every registered handshake output.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = 1'b0;
    awvalid_d   = M_AXI_AWVALID;
    wvalid_d    = M_AXI_WVALID;
    arvalid_d   = M_AXI_ARVALID;
    bready_d    = M_AXI_BREADY;
    rready_d    = M_AXI_RREADY;
    rsp_valid_d = RSP_VALID;
    latch_cmd   = 1'b0;
    latch_b     = 1'b0;
    latch_r     = 1'b0;
`ifdef AXIM_TIMEOUT_EN
    to_fire     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (CMD_VALID && CMD_READY) begin
          latch_cmd   = 1'b1;
          cmd_ready_d = 1'b0;
          if (CMD_WRITE) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        // AW and W retire independently; move on only once both have.
        if (M_AXI_AWVALID && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WVALID && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (M_AXI_BVALID && M_AXI_BREADY) begin
          latch_b     = 1'b1;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RD_REQ: begin
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (M_AXI_RVALID && M_AXI_RREADY) begin
          latch_r     = 1'b1;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (RSP_READY) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef AXIM_TIMEOUT_EN
    // Watchdog: a phase that has not completed by its last allowed cycle is
    // abandoned. Dropping a raised VALID breaks AXI rules on purpose; it is
    // only meant to recover from a hung slave.
    if ((state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA}) &&
        (state_d == state_q) &&
        (phase_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
      to_fire     = 1'b1;
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      arvalid_d   = 1'b0;
      bready_d    = 1'b0;
      rready_d    = 1'b0;
      rsp_valid_d = 1'b1;
      state_d     = RSP;
    end
`endif
  end

  // Registered handshake outputs, captured command and captured response.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      CMD_READY     <= 1'b0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      RSP_VALID     <= 1'b0;
      RSP_WRITE     <= 1'b0;
      RSP_RDATA     <= '0;
      RSP_RESP      <= 2'b00;
      M_AXI_AWADDR  <= '0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_ARADDR  <= '0;
    end else begin
      CMD_READY     <= cmd_ready_d;
      M_AXI_AWVALID <= awvalid_d;
      M_AXI_WVALID  <= wvalid_d;
      M_AXI_ARVALID <= arvalid_d;
      M_AXI_BREADY  <= bready_d;
      M_AXI_RREADY  <= rready_d;
      RSP_VALID     <= rsp_valid_d;
      if (latch_cmd) begin
        RSP_WRITE <= CMD_WRITE;
        if (CMD_WRITE) begin
          M_AXI_AWADDR <= CMD_ADDR;
          M_AXI_WDATA  <= CMD_WDATA;
          M_AXI_WSTRB  <= CMD_WSTRB;
        end else begin
          M_AXI_ARADDR <= CMD_ADDR;
        end
      end
      if (latch_b) begin
        RSP_RDATA <= '0;
        RSP_RESP  <= M_AXI_BRESP;
      end
      if (latch_r) begin
        RSP_RDATA <= M_AXI_RDATA;
        RSP_RESP  <= M_AXI_RRESP;
      end
`ifdef AXIM_TIMEOUT_EN
      if (to_fire) begin
        RSP_RDATA <= '0;
        RSP_RESP  <= 2'b11;
      end
`endif
    end
  end

`ifdef AXIM_TIMEOUT_EN
  // Per-phase stall counter: restarts on every state change.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN)
      phase_cnt_q <= '0;
    else if (state_d != state_q)
      phase_cnt_q <= '0;
    else if (state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA})
      phase_cnt_q <= phase_cnt_q + CNT_W'(1);
  end

  // Timeout flag: set on abort, cleared when the next command is taken.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN)  rsp_timeout_q <= 1'b0;
    else if (to_fire)    rsp_timeout_q <= 1'b1;
    else if (latch_cmd)  rsp_timeout_q <= 1'b0;
  end

  assign RSP_TIMEOUT = rsp_timeout_q;
`else
  assign RSP_TIMEOUT = 1'b0;
`endif

endmodule

// File: doc/axilite_master_engine.md
Name: axilite_master_engine

Overview:
- Single-outstanding AXI4-Lite master (initiator) that converts a simple command/response interface into AXI4-Lite write and read transactions.
- Drives the matrix-multiply accelerator's AXI-Lite slave from fabric: loads A/B rows, writes start, polls and reads results.
- Sits between a fabric-side sequencer and the accelerator's s00_axi port; it is the initiator end of that interface.

Parameters:
- C_M_AXI_DATA_WIDTH, 32, AXI data width, also the command/response data width.
- C_M_AXI_ADDR_WIDTH, 10, AXI byte address width.
- TIMEOUT_CYCLES, 1024, stall limit per channel phase; used only with AXIM_TIMEOUT_EN.

Ports:
- M_AXI_ACLK  in  1  clock.
- M_AXI_ARESETN  in  1  reset. One clock; reset is asynchronous and active-low.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  command accepted when CMD_VALID & CMD_READY.
- CMD_WRITE  in  1  1 = write, 0 = read.
- CMD_ADDR  in  ADDR_W  byte address.
- CMD_WDATA  in  DATA_W  write data.
- CMD_WSTRB  in  DATA_W/8  write strobes.
- RSP_VALID  out  1  response available.
- RSP_READY  in  1  response consumed.
- RSP_WRITE  out  1  echo of the command type.
- RSP_RDATA  out  DATA_W  read data; 0 for writes.
- RSP_RESP  out  2  BRESP or RRESP; 2'b11 on timeout.
- RSP_TIMEOUT  out  1  transaction aborted by the watchdog.
- BUSY  out  1  high in every state except IDLE.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master directions and widths.

Behaviour:
- Reset values: all VALID/READY outputs 0, CMD_READY 0 during reset, all data/addr/resp outputs 0, RSP_TIMEOUT 0, FSM in IDLE. Reset asserted mid-transaction aborts immediately and drops every valid.
- AWPROT = ARPROT = 3'b000. All AXI outputs are registered.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: CMD_READY = 1. On accept, latch addr, data, strb and type.
  - Write: go to WR_REQ with AWVALID = WVALID = 1 on the next cycle.
  - Read: go to RD_REQ with ARVALID = 1 on the next cycle.
- WR_REQ: AWVALID and WVALID are each held until their own handshake, then cleared independently. The two handshakes may occur in either order or in the same cycle. Leave for WR_RESP only when both are done.
- WR_RESP: BREADY = 1. On BVALID, latch BRESP and go to RSP. Do not enter WR_RESP early: a BVALID that arrives before both handshakes waits.
- RD_REQ: ARVALID held until ARREADY, then go to RD_DATA.
- RD_DATA: RREADY = 1. On RVALID, latch RDATA and RRESP, then go to RSP.
- RSP: RSP_VALID held until RSP_READY, then return to IDLE. CMD_READY is 0 here; no back-to-back overlap.
- Latency with zero-wait slave:
  - Write: accept at cycle 0, AW/W at cycle 1, B at cycle 2, RSP_VALID at cycle 3.
  - Read: accept at cycle 0, AR at cycle 1, R at cycle 2, RSP_VALID at cycle 3.
  - Minimum command-to-command spacing: 4 cycles.
- Non-OKAY responses (SLVERR/DECERR) are passed through in RSP_RESP. No retry.
- Address and data are held stable while their VALID is high.

Optional Feature:
- Macro: AXIM_TIMEOUT_EN.
- Defined:
  - A per-phase counter clears on every state entry and increments in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
  - When the count reaches TIMEOUT_CYCLES-1 without completing the phase, all AXI valids/readies drop and the FSM goes to RSP with RSP_TIMEOUT = 1, RSP_RESP = 2'b11, RSP_RDATA = 0.
  - Dropping an asserted valid is a deliberate AXI violation, accepted for hang recovery only.
- Undefined: no counter; the engine waits indefinitely; RSP_TIMEOUT is tied to 0.

Test Plan:
- Write addr 0x004, data 0xDEADBEEF, strb 4'hF, slave ready with zero wait -> AW/W valid at cycle 1, BREADY at cycle 2, RSP_VALID at cycle 3 with RSP_RESP = 0.
- Write where WREADY comes 3 cycles before AWREADY -> WVALID drops after its handshake, AWVALID stays high, BREADY rises only after the AW handshake, single response.
- Read addr 0x100, slave returns RDATA = 0x00000040 after 5 wait cycles -> RSP_RDATA = 0x00000040, RSP_WRITE = 0, ARVALID cleared after ARREADY.
- Slave returns BRESP = 2'b10 and RSP_READY is held low for 4 cycles -> RSP_VALID stays high, RSP_RESP = 2'b10, CMD_READY stays 0 until consumed.
- Reset asserted while in WR_REQ -> AWVALID and WVALID are 0 asynchronously, BUSY = 0; after release the next command is accepted from IDLE.
- With AXIM_TIMEOUT_EN defined and TIMEOUT_CYCLES = 16, ARREADY held at 0 -> ARVALID drops after 16 cycles, RSP_TIMEOUT = 1, RSP_RESP = 2'b11.
